communication_send: RTL

//  FPGA1-side serial transmitter feeding communication_receive on FPGA2. Serializes one

---
 rtl/comm_pkg.sv | 27 ++
 rtl/comm_bit_clk_gen.sv | 37 +++
 rtl/communication_send.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/comm_pkg.sv
// Shared types and helpers for the FPGA1 -> FPGA2 serial link.
// Define COMM_ODD_PARITY_EN to switch the frame parity bit to odd parity.
package comm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_ACK
   } tx_state_t;

   localparam int   DATA_BITS = 8;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
`ifdef COMM_ODD_PARITY_EN
      return ~^d;
`else
      return ^d;
`endif
   endfunction

endpackage

// File: rtl/comm_bit_clk_gen.sv
// Free-running bit clock: freq toggles every CLK_DIV clk, bit_tick marks
// the clk cycle whose closing edge takes freq from 1 to 0.
module comm_bit_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic freq,
   output logic bit_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          freq_q, freq_d;
   logic          wrap;

   always_comb begin
      wrap   = (cnt_q == CW'(CLK_DIV - 1));
      cnt_d  = wrap ? '0 : cnt_q + CW'(1);
      freq_d = wrap ? ~freq_q : freq_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         freq_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         freq_q <= freq_d;
      end
   end

   assign freq     = freq_q;
   assign bit_tick = wrap & freq_q;

endmodule

// File: rtl/communication_send.sv
// Serial frame transmitter: start, 8 data bits LSB first, parity, stop bits,
// then waits for the receiver ack. COMM_ODD_PARITY_EN selects odd parity.
module communication_send
   import comm_pkg::*;
#(
   parameter int CLK_DIV     = 4,
   parameter int STOP_BITS   = 3,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       rec_ack,
   output logic       freq,
   output logic       send_data,
   output logic       send_en,
   output logic       tx_busy,
   output logic       ack_timeout
);

   localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   tx_state_t      state_q, state_d;
   logic [7:0]     data_q, data_d;
   logic           par_q, par_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [SW-1:0]  stop_cnt_q, stop_cnt_d;
   logic [TW-1:0]  to_cnt_q, to_cnt_d;
   logic           ack_s1_q, ack_s2_q;
   logic           send_data_q, send_data_d;
   logic           send_en_q, send_en_d;
   logic           ack_timeout_q, ack_timeout_d;
   logic           bit_tick;

   comm_bit_clk_gen #(.CLK_DIV(CLK_DIV)) u_bit_clk (
      .clk      (clk),
      .rst_n    (rst_n),
      .freq     (freq),
      .bit_tick (bit_tick)
   );

   always_comb begin
      state_d       = state_q;
      data_d        = data_q;
      par_d         = par_q;
      bit_idx_d     = bit_idx_q;
      stop_cnt_d    = stop_cnt_q;
      to_cnt_d      = to_cnt_q;
      ack_timeout_d = 1'b0;
      unique case (state_q)
         IDLE: if (tx_valid) begin
            state_d = LOAD;
            data_d  = tx_data;
            par_d   = parity_bit(tx_data);
         end
         LOAD: if (bit_tick) state_d = START;
         START: if (bit_tick) begin
            state_d   = DATA;
            bit_idx_d = '0;
         end
         DATA: if (bit_tick) begin
            if (bit_idx_q == 3'd7) state_d = PARITY;
            else bit_idx_d = bit_idx_q + 3'd1;
         end
         PARITY: if (bit_tick) begin
            state_d    = STOP;
            stop_cnt_d = '0;
         end
         STOP: if (bit_tick) begin
            if (stop_cnt_q == SW'(STOP_BITS - 1)) begin
               state_d  = WAIT_ACK;
               to_cnt_d = '0;
            end else begin
               stop_cnt_d = stop_cnt_q + SW'(1);
            end
         end
         WAIT_ACK: begin
            // A level ack beats a timeout landing in the same cycle
            if (ack_s2_q) begin
               state_d = IDLE;
            end else if (bit_tick) begin
               if (to_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
                  state_d       = IDLE;
                  ack_timeout_d = 1'b1;
               end else begin
                  to_cnt_d = to_cnt_q + TW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line outputs follow the next state so they move on the tick edge
      send_data_d = LINE_IDLE;
      send_en_d   = 1'b0;
      unique case (state_d)
         START: begin
            send_data_d = START_BIT;
            send_en_d   = 1'b1;
         end
         DATA: begin
            send_data_d = data_q[bit_idx_d];
            send_en_d   = 1'b1;
         end
         PARITY: begin
            send_data_d = par_q;
            send_en_d   = 1'b1;
         end
         STOP: send_en_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         data_q        <= '0;
         par_q         <= 1'b0;
         bit_idx_q     <= '0;
         stop_cnt_q    <= '0;
         to_cnt_q      <= '0;
         ack_s1_q      <= 1'b0;
         ack_s2_q      <= 1'b0;
         send_data_q   <= LINE_IDLE;
         send_en_q     <= 1'b0;
         ack_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         data_q        <= data_d;
         par_q         <= par_d;
         bit_idx_q     <= bit_idx_d;
         stop_cnt_q    <= stop_cnt_d;
         to_cnt_q      <= to_cnt_d;
         ack_s1_q      <= rec_ack;
         ack_s2_q      <= ack_s1_q;
         send_data_q   <= send_data_d;
         send_en_q     <= send_en_d;
         ack_timeout_q <= ack_timeout_d;
      end
   end

   assign tx_ready    = (state_q == IDLE);
   assign tx_busy     = (state_q != IDLE);
   assign send_data   = send_data_q;
   assign send_en     = send_en_q;
   assign ack_timeout = ack_timeout_q;

endmodule
